// File: rtl/exec_unit_if.sv
// Request/response bundle between the issue logic, the execute stage and the
// register file write port.
interface exec_unit_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);
  logic              valid_i;
  logic              ready_o;
  logic [2:0]        op_i;
  logic [WIDTH-1:0]  operandA_i;
  logic [WIDTH-1:0]  operandB_i;
  logic [ADDR_W-1:0] destReg_i;
  logic [WIDTH-1:0]  data_o;
  logic [ADDR_W-1:0] destReg_o;
  logic              writeFlag_o;
  logic              zero_o;
  logic              carry_o;

  modport master (
    output valid_i, op_i, operandA_i, operandB_i, destReg_i,
    input  ready_o, data_o, destReg_o, writeFlag_o, zero_o, carry_o
  );

  modport slave (
    input  valid_i, op_i, operandA_i, operandB_i, destReg_i,
    output ready_o, data_o, destReg_o, writeFlag_o, zero_o, carry_o
  );
endinterface

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiplier
// that keeps the stage busy for WIDTH cycles.
module exec_unit #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  exec_unit_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  // Returns {carry, result}; carry is carry-out, borrow or last bit shifted out.
  function automatic logic [WIDTH:0] alu(input logic [2:0]       op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
    logic [WIDTH:0] wide;
    logic [WIDTH:0] shr;
    logic [2:0]     amt;
    amt  = b[2:0];
    wide = '0;
    shr  = {a, 1'b0} >> amt;
    case (op)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_SHL:  wide = {1'b0, a} << amt;
      OP_SHR:  wide = {shr[0], shr[WIDTH:1]};
      default: wide = '0;
    endcase
    return wide;
  endfunction

  state_t              state_p1, state_p0;
  logic [CNT_W-1:0]    cnt_p1, cnt_p0;
  logic [2*WIDTH-1:0]  acc_p1, acc_p0;
  logic [WIDTH-1:0]    a_p1, a_p0;
  logic [WIDTH-1:0]    b_p1, b_p0;
  logic [ADDR_W-1:0]   mdest_p1, mdest_p0;

  logic [WIDTH-1:0]    data_p1, data_p0;
  logic [ADDR_W-1:0]   dest_p1, dest_p0;
  logic                zero_p1, zero_p0;
  logic                carry_p1, carry_p0;
  logic                vld_p1, vld_p0;

  logic [WIDTH:0]      alu_res;
  logic [2*WIDTH-1:0]  addend;
  logic [2*WIDTH-1:0]  acc_sum;

  assign alu_res = alu(bus.op_i, bus.operandA_i, bus.operandB_i);
  assign addend  = b_p1[cnt_p1] ? ({{WIDTH{1'b0}}, a_p1} << cnt_p1) : '0;
  assign acc_sum = acc_p1 + addend;

  always_comb begin
    state_p0 = state_p1;
    cnt_p0   = cnt_p1;
    acc_p0   = acc_p1;
    a_p0     = a_p1;
    b_p0     = b_p1;
    mdest_p0 = mdest_p1;
    data_p0  = data_p1;
    dest_p0  = dest_p1;
    zero_p0  = zero_p1;
    carry_p0 = carry_p1;
    vld_p0   = 1'b0;
    case (state_p1)
      ST_IDLE: begin
        if (bus.valid_i) begin
          if (bus.op_i == OP_MUL) begin
            a_p0     = bus.operandA_i;
            b_p0     = bus.operandB_i;
            mdest_p0 = bus.destReg_i;
            acc_p0   = '0;
            cnt_p0   = '0;
            state_p0 = ST_MUL;
          end else begin
            data_p0  = alu_res[WIDTH-1:0];
            carry_p0 = alu_res[WIDTH];
            zero_p0  = (alu_res[WIDTH-1:0] == '0);
            dest_p0  = bus.destReg_i;
            vld_p0   = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_p0 = acc_sum;
        cnt_p0 = cnt_p1 + 1'b1;
        if (cnt_p1 == CNT_W'(WIDTH - 1)) begin
          data_p0  = acc_sum[WIDTH-1:0];
          carry_p0 = |acc_sum[2*WIDTH-1:WIDTH];
          zero_p0  = (acc_sum[WIDTH-1:0] == '0);
          dest_p0  = mdest_p1;
          vld_p0   = 1'b1;
          state_p0 = ST_IDLE;
        end
      end
      default: state_p0 = ST_IDLE;
    endcase
  end

  // Stage boundary: every architectural register, including the result outputs, resets
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1 <= ST_IDLE;
      cnt_p1   <= '0;
      acc_p1   <= '0;
      a_p1     <= '0;
      b_p1     <= '0;
      mdest_p1 <= '0;
      data_p1  <= '0;
      dest_p1  <= '0;
      zero_p1  <= 1'b0;
      carry_p1 <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      state_p1 <= state_p0;
      cnt_p1   <= cnt_p0;
      acc_p1   <= acc_p0;
      a_p1     <= a_p0;
      b_p1     <= b_p0;
      mdest_p1 <= mdest_p0;
      data_p1  <= data_p0;
      dest_p1  <= dest_p0;
      zero_p1  <= zero_p0;
      carry_p1 <= carry_p0;
      vld_p1   <= vld_p0;
    end
  end

  assign bus.ready_o     = (state_p1 == ST_IDLE);
  assign bus.data_o      = data_p1;
  assign bus.destReg_o   = dest_p1;
  assign bus.zero_o      = zero_p1;
  assign bus.carry_o     = carry_p1;
  assign bus.writeFlag_o = vld_p1;
endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit; expected write-backs queue up as ops are
// driven and are retired against each writeFlag_o strobe.
module tb_exec_unit;
  typedef struct packed {
    logic [7:0] data;
    logic [2:0] dest;
    logic       zero;
    logic       carry;
  } wb_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_pass  = 0;
  wb_t  sb[$];

  exec_unit_if #(.WIDTH(8), .ADDR_W(3)) bus ();

  exec_unit #(.WIDTH(8), .ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] d);
    bus.valid_i    = v;
    bus.op_i       = op;
    bus.operandA_i = a;
    bus.operandB_i = b;
    bus.destReg_i  = d;
  endtask

  task automatic push(input logic [7:0] data, input logic [2:0] dest,
                      input logic zero, input logic carry);
    wb_t e;
    e.data = data; e.dest = dest; e.zero = zero; e.carry = carry;
    sb.push_back(e);
  endtask

  // Advance one edge, then check the strobe and retire a write-back if present.
  task automatic cycle(input string tag, input logic exp_wf);
    wb_t e;
    @(posedge clk);
    #1;
    chk({tag, "_wf"}, 16'(bus.writeFlag_o), 16'(exp_wf));
    if (bus.writeFlag_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk({tag, "_unexpected_wb"}, 16'(1), 16'(0));
      end else begin
        e = sb.pop_front();
        chk({tag, "_data"},  16'(bus.data_o),    16'(e.data));
        chk({tag, "_dest"},  16'(bus.destReg_o), 16'(e.dest));
        chk({tag, "_zero"},  16'(bus.zero_o),    16'(e.zero));
        chk({tag, "_carry"}, 16'(bus.carry_o),   16'(e.carry));
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"},  16'(bus.data_o),    16'(0));
    chk({tag, "_dest"},  16'(bus.destReg_o), 16'(0));
    chk({tag, "_zero"},  16'(bus.zero_o),    16'(0));
    chk({tag, "_carry"}, 16'(bus.carry_o),   16'(0));
    chk({tag, "_ready"}, 16'(bus.ready_o),   16'(1));
  endtask

  initial begin
    // Reset held two cycles with a request pending
    rst_n = 1'b0;
    drive(1'b1, 3'd0, 8'd1, 8'd1, 3'd1);
    cycle("rst0", 1'b0);
    chk_reset_outputs("rst0");
    cycle("rst1", 1'b0);
    chk_reset_outputs("rst1");
    drive(1'b0, 3'd0, 8'd0, 8'd0, 3'd0);
    rst_n = 1'b1;
    cycle("post_rst", 1'b0);
    chk("post_rst_ready", 16'(bus.ready_o), 16'(1));

    // ADD 200+100 wraps to 44 with carry
    drive(1'b1, 3'd0, 8'd200, 8'd100, 3'd3);
    push(8'd44, 3'd3, 1'b0, 1'b1);
    cycle("add", 1'b1);
    drive(1'b0, 3'd0, 8'd0, 8'd0, 3'd0);
    cycle("add_end", 1'b0);
    chk("add_hold_data", 16'(bus.data_o), 16'(44));

    // SUB, SHL, XOR back-to-back
    drive(1'b1, 3'd1, 8'd5, 8'd7, 3'd1);
    push(8'd254, 3'd1, 1'b0, 1'b1);
    cycle("sub", 1'b1);
    drive(1'b1, 3'd5, 8'h81, 8'd1, 3'd2);
    push(8'h02, 3'd2, 1'b0, 1'b1);
    cycle("shl", 1'b1);
    drive(1'b1, 3'd4, 8'h5A, 8'h5A, 3'd4);
    push(8'd0, 3'd4, 1'b1, 1'b0);
    cycle("xor", 1'b1);
    drive(1'b0, 3'd0, 8'd0, 8'd0, 3'd0);
    cycle("b2b_end", 1'b0);

    // MUL 13x11 with an ADD held during the busy window
    drive(1'b1, 3'd7, 8'd13, 8'd11, 3'd5);
    cycle("mul_acc", 1'b0);
    chk("mul_busy0", 16'(bus.ready_o), 16'(0));
    drive(1'b1, 3'd0, 8'd1, 8'd2, 3'd6);
    for (int k = 1; k < 8; k++) begin
      cycle("mul_busy", 1'b0);
      chk("mul_busy", 16'(bus.ready_o), 16'(0));
    end
    push(8'd143, 3'd5, 1'b0, 1'b0);
    cycle("mul_done", 1'b1);
    chk("mul_done_ready", 16'(bus.ready_o), 16'(1));
    push(8'd3, 3'd6, 1'b0, 1'b0);
    cycle("held_add", 1'b1);
    drive(1'b0, 3'd0, 8'd0, 8'd0, 3'd0);
    cycle("held_add_end", 1'b0);

    // MUL 16x16: low byte zero, high byte non-zero
    drive(1'b1, 3'd7, 8'd16, 8'd16, 3'd7);
    cycle("mul16_acc", 1'b0);
    drive(1'b0, 3'd0, 8'd0, 8'd0, 3'd0);
    for (int k = 1; k < 8; k++) cycle("mul16_busy", 1'b0);
    push(8'd0, 3'd7, 1'b1, 1'b1);
    cycle("mul16_done", 1'b1);
    cycle("mul16_end", 1'b0);

    // Reset aborts a MUL after four iterations
    drive(1'b1, 3'd7, 8'd255, 8'd255, 3'd1);
    cycle("mulrst_acc", 1'b0);
    drive(1'b0, 3'd0, 8'd0, 8'd0, 3'd0);
    for (int k = 0; k < 4; k++) cycle("mulrst_iter", 1'b0);
    rst_n = 1'b0;
    cycle("mulrst_rst", 1'b0);
    chk_reset_outputs("mulrst");
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) cycle("mulrst_quiet", 1'b0);
    chk("mulrst_ready", 16'(bus.ready_o), 16'(1));
    drive(1'b1, 3'd0, 8'd1, 8'd1, 3'd2);
    push(8'd2, 3'd2, 1'b0, 1'b0);
    cycle("add_after_rst", 1'b1);
    drive(1'b0, 3'd0, 8'd0, 8'd0, 3'd0);
    cycle("final", 1'b0);

    chk("sb_empty", 16'(sb.size()), 16'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
